tdm_demux4: RTL and testbench

Four-channel time-division demultiplexer: the receive end of the rotating-select 4:1 mux path. It takes one slot per valid beat from a shared line and tracks frame alignment with a sync marker. It distributes each slot to its own registered channel output and publishes all four channels together once per complete frame. It sits between the serial link from the transmit-side mux and the per-channel consumers.

---
 rtl/tdm_demux_pkg.sv | 27 ++
 rtl/tdm_slot_cnt.sv | 43 ++++
 rtl/tdm_demux4.sv | 154 +++++++++++++++
 tb/tb_tdm_demux4.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_demux_pkg                                                        |
// | Shared types and constants for the 4-channel TDM demultiplexer.      |
// | Macro: TDM_DEMUX_PARITY_EN adds a fifth (parity) slot per frame.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package tdm_demux_pkg;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int NUM_CH = 4;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int NSLOT = 5;
`else
  localparam int NSLOT = 4;
`endif

  localparam int CNT_W = $clog2(NSLOT);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NSLOT - 1);

endpackage
`default_nettype wire

// File: rtl/tdm_slot_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_slot_cnt                                                         |
// | Slot position counter for the TDM demultiplexer, 0..NSLOT-1.         |
// | Ports: clk, rst_n (async, active low)                                |
// |        adv   - step to the next slot (wraps after the last slot)     |
// |        load1 - current beat is slot 0, next beat is slot 1           |
// |        clr   - return to slot 0                                      |
// |        cnt   - current slot index, last - cnt is the final slot      |
// | Macro: TDM_DEMUX_PARITY_EN (via package, sets NSLOT)                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tdm_slot_cnt
  import tdm_demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             load1,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (load1) begin
      r_cnt <= CNT_W'(1);
    end else if (adv) begin
      r_cnt <= (r_cnt == LAST_SLOT) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign cnt  = r_cnt;
  assign last = (r_cnt == LAST_SLOT);

endmodule
`default_nettype wire

// File: rtl/tdm_demux4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_demux4                                                           |
// | Four-channel TDM demultiplexer with sync-marker frame alignment.     |
// | Slots are collected in shadow registers and published to y0..y3     |
// | together once per complete frame.                                    |
// | Ports: clk, rst_n (async, active low)                                |
// |        din/din_vld/sync - line input, sync marks slot 0              |
// |        y0..y3           - registered channel outputs                 |
// |        frame_vld        - pulse, y0..y3 just updated                 |
// |        locked           - alignment FSM in LOCKED                    |
// |        sync_err         - pulse on an alignment violation            |
// |        parity_err       - pulse with frame_vld on parity mismatch    |
// | Macro: TDM_DEMUX_PARITY_EN - fifth slot carries even parity; when    |
// |        undefined parity_err is tied low.                             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  input  logic             sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_vld,
  output logic             locked,
  output logic             sync_err,
  output logic             parity_err
);

  state_t           r_state;
  logic [WIDTH-1:0] r_shadow [NUM_CH];
  logic [WIDTH-1:0] r_y      [NUM_CH];
  logic             r_frame_vld;
  logic             r_sync_err;

  logic [CNT_W-1:0] w_cnt;
  logic             w_last;
  logic             w_cnt_zero;
  logic             w_adv;
  logic             w_load1;
  logic             w_clr;

  assign w_cnt_zero = (w_cnt == '0);

  // Counter control. A qualified sync beat is always slot 0, whether it
  // acquires lock from HUNT or re-aligns a LOCKED stream.
  always_comb begin
    w_adv   = 1'b0;
    w_load1 = 1'b0;
    w_clr   = 1'b0;
    if (din_vld) begin
      if (sync) begin
        w_load1 = 1'b1;
      end else if (r_state == LOCKED) begin
        if (w_cnt_zero) begin
          w_clr = 1'b1;
        end else begin
          w_adv = 1'b1;
        end
      end
    end
  end

  tdm_slot_cnt u_slot_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (w_adv),
    .load1 (w_load1),
    .clr   (w_clr),
    .cnt   (w_cnt),
    .last  (w_last)
  );

`ifdef TDM_DEMUX_PARITY_EN
  logic r_parity_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_frame_vld <= 1'b0;
      r_sync_err  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= '0;
        r_y[i]      <= '0;
      end
    end else begin
      r_frame_vld <= 1'b0;
      r_sync_err  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (din_vld) begin
        if (sync) begin
          // Sync mid-frame drops the partial frame simply by restarting
          // the shadow fill at slot 0; outputs are untouched.
          r_shadow[0] <= din;
          r_state     <= LOCKED;
          if ((r_state == LOCKED) && !w_cnt_zero) begin
            r_sync_err <= 1'b1;
          end
        end else if (r_state == LOCKED) begin
          if (w_cnt_zero) begin
            r_sync_err <= 1'b1;
            r_state    <= HUNT;
          end else if (w_last) begin
            r_frame_vld <= 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
            // Current beat is the parity slot; only its bit 0 matters.
            for (int i = 0; i < NUM_CH; i++) begin
              r_y[i] <= r_shadow[i];
            end
            r_parity_err <= (^{r_shadow[0], r_shadow[1], r_shadow[2], r_shadow[3]}) != din[0];
`else
            // Current beat is channel 3 itself and bypasses the shadow.
            r_y[0] <= r_shadow[0];
            r_y[1] <= r_shadow[1];
            r_y[2] <= r_shadow[2];
            r_y[3] <= din;
`endif
          end else begin
            r_shadow[w_cnt[1:0]] <= din;
          end
        end
      end
    end
  end

  assign y0        = r_y[0];
  assign y1        = r_y[1];
  assign y2        = r_y[2];
  assign y3        = r_y[3];
  assign frame_vld = r_frame_vld;
  assign locked    = (r_state == LOCKED);
  assign sync_err  = r_sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tdm_demux4                                                        |
// | Self-checking bench for tdm_demux4: per-beat table of stimulus and   |
// | expected flags, with published frames checked from a scoreboard.     |
// | Macro: TDM_DEMUX_PARITY_EN selects the parity-slot frame format.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_tdm_demux4;

  localparam int W = 4;
`ifdef TDM_DEMUX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_vld;
  logic         sync;
  logic [W-1:0] y0, y1, y2, y3;
  logic         frame_vld, locked, sync_err, parity_err;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_vld    (din_vld),
    .sync       (sync),
    .y0         (y0),
    .y1         (y1),
    .y2         (y2),
    .y3         (y3),
    .frame_vld  (frame_vld),
    .locked     (locked),
    .sync_err   (sync_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           vld;
    logic           sync;
    logic [W-1:0]   din;
    logic           fv;
    logic           lk;
    logic           se;
    logic           pe;
    logic           pub;
    logic [4*W-1:0] ey;
  } vec_t;

  vec_t           tbl[$];
  logic [4*W-1:0] sb[$];
  logic [4*W-1:0] held;
  int             total  = 0;
  int             passes = 0;
  int             row_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic v, input logic s, input logic [W-1:0] d,
                     input logic fv, input logic lk, input logic se, input logic pe,
                     input logic pub, input logic [4*W-1:0] ey);
    vec_t r;
    r.vld = v; r.sync = s; r.din = d; r.fv = fv; r.lk = lk; r.se = se;
    r.pe = pe; r.pub = pub; r.ey = ey;
    tbl.push_back(r);
  endtask

  // Non-publishing row: expected frame_vld and parity_err low.
  task automatic beat(input logic v, input logic s, input logic [W-1:0] d,
                      input logic lk, input logic se);
    add(v, s, d, 1'b0, lk, se, 1'b0, 1'b0, '0);
  endtask

  // One complete frame starting with a sync beat; `gap` idle cycles
  // (with a stray sync on the first) between beats.
  task automatic add_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d,
                           input int gap, input bit serr_first, input bit bad_par);
    logic [W-1:0] s [4];
    logic         p;
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
    for (int k = 0; k < 4; k++) begin
      if (k > 0)
        for (int g = 0; g < gap; g++) beat(1'b0, g == 0, W'(g + 5), 1'b1, 1'b0);
      add(1'b1, k == 0, s[k], (k == 3) && !PAR, 1'b1, (k == 0) && serr_first,
          1'b0, (k == 3) && !PAR, {a, b, c, d});
    end
    if (PAR) begin
      for (int g = 0; g < gap; g++) beat(1'b0, 1'b0, W'(g + 9), 1'b1, 1'b0);
      p = (^{a, b, c, d}) ^ bad_par;
      add(1'b1, 1'b0, {{(W-1){1'b1}}, p}, 1'b1, 1'b1, 1'b0, bad_par, 1'b1, {a, b, c, d});
    end
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      @(negedge clk);
      din     = tbl[i].din;
      din_vld = tbl[i].vld;
      sync    = tbl[i].sync;
      if (tbl[i].pub) sb.push_back(tbl[i].ey);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d flags{fv,lk,se,pe}", row_no),
          32'({frame_vld, locked, sync_err, parity_err}),
          32'({tbl[i].fv, tbl[i].lk, tbl[i].se, tbl[i].pe}));
      if (!tbl[i].fv) chk($sformatf("row%0d y hold", row_no), 32'({y0, y1, y2, y3}), 32'(held));
      else held = tbl[i].ey;
      row_no++;
    end
    tbl.delete();
    @(negedge clk);
    din_vld = 1'b0;
    sync    = 1'b0;
  endtask

  // Frame scoreboard: each frame_vld cycle must match the oldest pending frame.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && frame_vld === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL frame_vld: pulse with no expected frame, y=%h", {y0, y1, y2, y3});
      end else begin
        chk("frame y0..y3", 32'({y0, y1, y2, y3}), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0; din = '0; din_vld = 1'b0; sync = 1'b0; held = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset y", 32'({y0, y1, y2, y3}), 32'h0);
    chk("reset flags", 32'({frame_vld, locked, sync_err, parity_err}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    beat(1'b1, 1'b0, 4'h5, 1'b0, 1'b0);            // HUNT drops non-sync beat
    beat(1'b0, 1'b1, 4'h6, 1'b0, 1'b0);            // sync without din_vld ignored
    add_frame(4'h1, 4'h0, 4'h1, 4'h1, 0, 0, 0);
    add_frame(4'hA, 4'h3, 4'hC, 4'h6, 2, 0, 0);    // gaps between beats
    add_frame(4'h9, 4'hE, 4'h5, 4'h2, 0, 0, 0);    // back-to-back
    beat(1'b1, 1'b1, 4'h1, 1'b1, 1'b0);            // partial frame, resync on beat 3
    beat(1'b1, 1'b0, 4'h2, 1'b1, 1'b0);
    add_frame(4'h7, 4'h0, 4'h1, 4'h0, 0, 1, 0);
    beat(1'b1, 1'b1, 4'hB, 1'b1, 1'b0);            // resync on the 4th beat slot
    beat(1'b1, 1'b0, 4'hC, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 4'hD, 1'b1, 1'b0);
    add_frame(4'h3, 4'h5, 4'h6, 4'h9, 0, 1, 0);
    beat(1'b1, 1'b0, 4'hF, 1'b0, 1'b1);            // boundary without sync -> HUNT
    beat(1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
    add_frame(4'hC, 4'hA, 4'hF, 4'hE, 1, 0, 0);
`ifdef TDM_DEMUX_PARITY_EN
    add_frame(4'h1, 4'h1, 4'h0, 4'h1, 0, 0, 0);
    add_frame(4'h1, 4'h1, 4'h0, 4'h1, 0, 0, 1);
`endif
    run_table();

    // Asynchronous reset two beats into a frame.
    @(negedge clk);
    din = 4'h3; din_vld = 1'b1; sync = 1'b1;
    @(negedge clk);
    din = 4'h4; sync = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset y", 32'({y0, y1, y2, y3}), 32'h0);
    chk("async reset flags", 32'({frame_vld, locked, sync_err, parity_err}), 32'h0);
    @(posedge clk);
    @(negedge clk);
    din_vld = 1'b0;
    rst_n   = 1'b1;
    held    = '0;

    beat(1'b1, 1'b0, 4'h8, 1'b0, 1'b0);            // back in HUNT after reset
    add_frame(4'h6, 4'hD, 4'h2, 4'hB, 0, 0, 0);
    run_table();

    repeat (2) @(posedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
